// File: rtl/onset_history_encoder_pkg.sv
// Shared definitions for the onset history encoder and the net controller that consumes it.
package onset_history_encoder_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int unsigned OVR_W_DEFAULT = 8;

endpackage

// File: rtl/onset_sync.sv
// Two-flop synchroniser for the raw onset pulse followed by a rising-edge detector.
module onset_sync (
    input  logic clock,
    input  logic reset,
    input  logic onsetIn,
    output logic onsetRise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= onsetIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A level held high yields exactly one rise.
    assign onsetRise = sync2 & ~prev;

endmodule

// File: rtl/onset_history_encoder.sv
// Quantises synchronised onsets into ticks, keeps a per-tick history and launches the net with
// a frozen snapshot, counting ticks that arrive while the net is still busy.
module onset_history_encoder
    import onset_history_encoder_pkg::*;
#(
    parameter int unsigned N_INPUTS    = 4,
    parameter int unsigned TICK_DIVIDE = 32'd1000,
    parameter int unsigned OVR_W       = OVR_W_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                onsetIn,
    input  logic                resultReady,
    output logic [N_INPUTS-1:0] inputBus,
    output logic                trigger,
    output logic                busy,
    output logic [OVR_W-1:0]    overrunCount
);

    localparam int unsigned TW = $clog2(TICK_DIVIDE);
    localparam int unsigned FW = $clog2(N_INPUTS + 1);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIVIDE - 1);
    localparam logic [FW-1:0] FILL_FULL   = FW'(N_INPUTS);
    localparam logic [FW-1:0] FILL_LAST   = FW'(N_INPUTS - 1);

    logic                onset_rise;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic                seen;
    logic [N_INPUTS-1:0] history;
    logic [N_INPUTS-1:0] history_next;
    logic [FW-1:0]       fill_count;
    logic                primed_next;
    state_t              state;
    logic                pending;

    onset_sync u_onset_sync (
        .clock     (clock),
        .reset     (reset),
        .onsetIn   (onsetIn),
        .onsetRise (onset_rise)
    );

    // A rise in the tick cycle itself still belongs to the tick being closed.
    always_comb begin
        tick         = (tick_cnt == '0);
        history_next = {history[N_INPUTS-2:0], seen | onset_rise};
        primed_next  = (fill_count >= FILL_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt   <= TICK_RELOAD;
            seen       <= 1'b0;
            history    <= '0;
            fill_count <= '0;
        end else begin
            tick_cnt <= tick ? TICK_RELOAD : tick_cnt - 1'b1;
            seen     <= tick ? 1'b0 : (seen | onset_rise);
            if (tick) begin
                history <= history_next;
                if (fill_count != FILL_FULL) begin
                    fill_count <= fill_count + 1'b1;
                end
            end
        end
    end

    // resultReady in the launch cycle itself cannot belong to that launch, so it is ignored,
    // which also keeps trigger from firing on consecutive cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            trigger      <= 1'b0;
            busy         <= 1'b0;
            inputBus     <= '0;
            overrunCount <= '0;
        end else begin
            trigger <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (tick && primed_next) begin
                        inputBus <= history_next;
                        trigger  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resultReady && !trigger) begin
                        if (tick) begin
                            inputBus <= history_next;
                            trigger  <= 1'b1;
                            pending  <= 1'b0;
                        end else if (pending) begin
                            inputBus <= history;
                            trigger  <= 1'b1;
                            pending  <= 1'b0;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (tick) begin
                        pending <= 1'b1;
                        if (overrunCount != '1) begin
                            overrunCount <= overrunCount + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/onset_history_encoder.md
# onset_history_encoder

Upstream feature stage for the LUT feed-forward beat-prediction net. It synchronises a raw onset pulse and quantises it into fixed-length ticks. It keeps a shift-register history of onset/no-onset per tick, and presents the latest N_INPUTS-tick history to the net with a one-cycle `trigger`. It then waits for the net's `resultReady` before launching again, counting ticks that were skipped while the net was busy.

## Interface
- N_INPUTS, 4: history length in ticks; width of `inputBus`.
- TICK_DIVIDE, 32'd1000: clock cycles per tick (≥2).
- OVR_W, 8: width of the overrun counter.

- clock  in  1  system clock; single clock domain; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- onsetIn  in  1  raw onset pulse, asynchronous to `clock`; any width ≥1 cycle high.
- resultReady  in  1  one-cycle completion pulse from the net.
- inputBus  out  N_INPUTS  frozen history snapshot; bit 0 = newest tick.
- trigger  out  1  one-cycle launch pulse to the net.
- busy  out  1  high while waiting for `resultReady`.
- overrunCount  out  OVR_W  saturating count of ticks that landed while busy.

## Operation
- Sync: two-flop synchroniser on `onsetIn`, then rising-edge detect giving `onsetRise`. A level held high produces one rise.
- Seen flag: set by `onsetRise`; cleared on each tick.
- Tick counter: loads TICK_DIVIDE-1 on reset and counts down. `tick` is asserted when the counter is 0, and the counter reloads in that cycle.
- On `tick`:
  - history ← {history[N_INPUTS-2:0], seen | onsetRise}.
  - `onsetRise` in the tick cycle lands in that tick's bit, not the next.
  - Multiple rises in one tick give a single 1.
  - fillCount increments, saturating at N_INPUTS. primed = (fillCount == N_INPUTS).
- FSM states S_IDLE and S_WAIT; the `pending` flag is cleared on reset.
  - S_IDLE, cycle after a tick that leaves primed=1: inputBus ← history, trigger=1 for one cycle, go to S_WAIT.
  - S_WAIT, tick without `resultReady`: pending=1; overrunCount+1, saturating at 2^OVR_W-1.
  - S_WAIT, `resultReady`: if pending, clear pending, snapshot history, pulse trigger next cycle, stay in S_WAIT. Otherwise go to S_IDLE.
  - S_WAIT, tick and `resultReady` in the same cycle: treated as completion followed by a new tick. Trigger pulses next cycle with the updated history; overrunCount is unchanged.
  - `resultReady` in S_IDLE: ignored.
- `inputBus` only changes in the cycle `trigger` asserts, so it is stable during the net's whole computation.

## Timing
- Reset values: inputBus=0, trigger=0, busy=0, overrunCount=0. Also cleared: history, seen, fillCount, pending, and the sync flops. Tick counter = TICK_DIVIDE-1.
- First tick: TICK_DIVIDE cycles after reset deasserts. First trigger: one cycle after the N_INPUTS-th tick.
- Onset latency: rising `onsetIn` sampled at edge k asserts `onsetRise` at edge k+2 (2-flop sync plus edge detect).
- Tick to trigger: 1 cycle. `resultReady` (pending) to trigger: 1 cycle.
- busy = (state == S_WAIT), registered.
- Reset mid-S_WAIT: immediate return to S_IDLE with everything cleared. Priming restarts, so there is no trigger until N_INPUTS new ticks have elapsed.
- trigger never asserts on two consecutive cycles. At most one launch is outstanding.

## Structure
- Shared package: FSM state encodings (S_IDLE, S_WAIT) and the default OVR_W. The net's controller uses the same state-name constants.
- One sub-module: `onset_sync` (two-flop synchroniser plus rising-edge detector, output `onsetRise`).
- Tick counter, history/fill logic and the FSM live in the top.

## Test plan
All cases use TICK_DIVIDE=4 and N_INPUTS=4; the responder returns `resultReady` 3 cycles after `trigger` unless stated.
- Reset release, no onsets -> no trigger for the first 15 cycles. Trigger at cycle 16 with inputBus=4'b0000; all outputs 0 during reset.
- Onsets in ticks 1..4 = 1,0,1,1 -> first trigger shows inputBus=4'b1011. Next tick with no onset -> 4'b0110.
- Responder holds `resultReady` low for 2 further ticks -> overrunCount=2 and busy stays 1. On `resultReady`, trigger pulses 1 cycle later with history including both skipped ticks.
- `resultReady` coincident with a tick in S_WAIT -> trigger next cycle, overrunCount unchanged.
- `onsetRise` on the tick cycle -> the bit lands in that tick. Two onsets in one tick -> a single 1. Level held high for 3 ticks -> only the first tick's bit is set.
- Assert reset while busy=1 -> busy=0, overrunCount=0, then no trigger until 4 ticks after release. Overrun saturation: with OVR_W=2 and 5 overrun ticks -> overrunCount=3.
